// File: rtl/cat_trap_core.sv
// cat_trap_core: "trap the cat" game core with a cursor, a blocked-cell map, a
// greedy N/W/S/E cat and a registered per-cell query port for the renderer.
module cat_trap_core #(
  parameter int GRID = 8,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          BtnC,
  input  logic          BtnU,
  input  logic          BtnD,
  input  logic          BtnL,
  input  logic          BtnR,
  input  logic [CW-1:0] q_x,
  input  logic [CW-1:0] q_y,
  output logic          q_blocked,
  output logic          q_cat,
  output logic          q_cursor,
  output logic [2:0]    state,
  output logic [CW-1:0] cat_x,
  output logic [CW-1:0] cat_y,
  output logic [CW-1:0] cur_x,
  output logic [CW-1:0] cur_y,
  output logic [7:0]    move_count
);
  localparam int N = GRID * GRID;
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] MAXC = CW'(GRID - 1);
  localparam logic [CW-1:0] CTR = CW'(GRID / 2);
  typedef enum logic [2:0] {
    START    = 3'b001,
    PLAY     = 3'b010,
    CAT_MOVE = 3'b011,
    GAMEOVER = 3'b100,
    GAMEWIN  = 3'b101
  } st_t;
  st_t st, nxt;
  logic [N-1:0] map;
  logic [4:0] btn, prev, edges;
  logic armed;
  logic act_c, act_u, act_d, act_l, act_r;
  logic cur_is_cat, cur_blk, place;
  logic n_free, w_free, s_free, e_free, any_free, border;
  logic [CW-1:0] nx, ny;
  logic q_in;
  function automatic logic [IW-1:0] idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return IW'(y) * IW'(GRID) + IW'(x);
  endfunction
  assign state = st;
  assign btn = {BtnC, BtnU, BtnD, BtnL, BtnR};
  // the first cycle after reset only learns the levels, so held buttons stay silent
  assign edges = armed ? (btn & ~prev) : 5'b0;
  assign act_c = edges[4];
  assign act_u = edges[3] & ~edges[4];
  assign act_d = edges[2] & ~|edges[4:3];
  assign act_l = edges[1] & ~|edges[4:2];
  assign act_r = edges[0] & ~|edges[4:1];
  assign cur_is_cat = (cur_x == cat_x) && (cur_y == cat_y);
  assign cur_blk = map[idx(cur_x, cur_y)];
  assign place = act_c && !cur_blk && !cur_is_cat;
  // the cat is never on a border while moving, so +/-1 never leaves the grid
  assign n_free = !map[idx(cat_x, cat_y - 1'b1)];
  assign w_free = !map[idx(cat_x - 1'b1, cat_y)];
  assign s_free = !map[idx(cat_x, cat_y + 1'b1)];
  assign e_free = !map[idx(cat_x + 1'b1, cat_y)];
  assign any_free = n_free | w_free | s_free | e_free;
  assign nx = n_free ? cat_x : w_free ? cat_x - 1'b1 : s_free ? cat_x : cat_x + 1'b1;
  assign ny = n_free ? cat_y - 1'b1 : w_free ? cat_y : s_free ? cat_y + 1'b1 : cat_y;
  assign border = (nx == '0) || (ny == '0) || (nx == MAXC) || (ny == MAXC);
  assign q_in = ({1'b0, q_x} < (CW + 1)'(GRID)) && ({1'b0, q_y} < (CW + 1)'(GRID));
  always_ff @(posedge clk or posedge Reset)
    if (Reset) st <= START;
    else st <= nxt;
  always_comb begin
    nxt = st;
    unique case (st)
      START:    nxt = (act_c && cur_is_cat) ? PLAY : START;
      PLAY:     nxt = place ? CAT_MOVE : PLAY;
      CAT_MOVE: nxt = !any_free ? GAMEWIN : border ? GAMEOVER : PLAY;
      GAMEOVER,
      GAMEWIN:  nxt = act_c ? START : st;
      default:  nxt = START;
    endcase
  end
  always_ff @(posedge clk or posedge Reset)
    if (Reset) begin
      map <= '0;
      cat_x <= CTR;
      cat_y <= CTR;
      cur_x <= CTR;
      cur_y <= CTR;
      move_count <= '0;
      prev <= '0;
      armed <= 1'b0;
      q_blocked <= 1'b0;
      q_cat <= 1'b0;
      q_cursor <= 1'b0;
    end else begin
      prev <= btn;
      armed <= 1'b1;
      q_blocked <= q_in && map[idx(q_x, q_y)];
      q_cat <= q_in && (q_x == cat_x) && (q_y == cat_y);
      q_cursor <= q_in && (q_x == cur_x) && (q_y == cur_y);
      if (st == START || st == PLAY) begin
        if (act_u && cur_y != '0) cur_y <= cur_y - 1'b1;
        if (act_d && cur_y != MAXC) cur_y <= cur_y + 1'b1;
        if (act_l && cur_x != '0) cur_x <= cur_x - 1'b1;
        if (act_r && cur_x != MAXC) cur_x <= cur_x + 1'b1;
      end
      if (st == START && act_c && !cur_is_cat) map[idx(cur_x, cur_y)] <= !cur_blk;
      if (st == PLAY && place) begin
        map[idx(cur_x, cur_y)] <= 1'b1;
        move_count <= (move_count == 8'hff) ? move_count : move_count + 1'b1;
      end
      if (st == CAT_MOVE && any_free) begin
        cat_x <= nx;
        cat_y <= ny;
      end
      if ((st == GAMEOVER || st == GAMEWIN) && act_c) begin
        map <= '0;
        cat_x <= CTR;
        cat_y <= CTR;
        cur_x <= CTR;
        cur_y <= CTR;
        move_count <= '0;
      end
    end
endmodule
